bitstream_packer: RTL
=====================

Name: bitstream_packer

Overview:
- Write-side counterpart of the decoder's bitstream buffer. Packs variable-length codes (value, length) from the encoder/syntax writer into 16-bit words, MSB-first, and writes them sequentially into bitstream RAM.
- Word bit 15 is the earliest bit, so the decoder-side buffer reads the packed stream back in order.
- Handles end-of-stream flush with optional RBSP trailing bits, and stops when the address space is full.

Parameters:
ADDR_W, 17, RAM word-address width; capacity is 2^ADDR_W words

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
start  input  1  pulse: clear accumulator, address and state; begin new stream
code_valid  input  1  code_value/code_len valid
code_value  input  16  code bits, right-aligned; bits at or above code_len are ignored
code_len  input  5  number of bits, 0..16; values 17..31 are treated as 16
code_ready  output  1  packer accepts a code this cycle
flush  input  1  pulse: pad and write the final partial word
flush_done  output  1  one-cycle pulse when the flush is complete
ram_wen  output  1  RAM write strobe
ram_waddr  output  ADDR_W  RAM write address
ram_wdata  output  16  RAM write data
words_written  output  ADDR_W+1  number of words written since start/reset
full  output  1  last RAM address has been written

Behaviour:
- Reset (async, reset_n=0): state RUN; acc=0; bit_cnt=0; ram_wen=0; ram_waddr=0; ram_wdata=0; words_written=0; full=0; flush_done=0.
- start has priority over every other input in any state. It gives the same register values as reset on the next edge.
- Internal state:
  - acc[31:0]: bits left-aligned.
  - bit_cnt[5:0]: number of valid bits in acc. Invariant: bit_cnt <= 15 at every clock edge.
- code_ready = (state==RUN) && !full && !start.
- Accept: a code is accepted when code_valid && code_ready.
  - The masked value is placed at acc bit positions [31-bit_cnt : 32-bit_cnt-len].
  - new_cnt = bit_cnt + len.
  - len=0 is accepted as a no-op.
- Emit rule (combinational check after appending): if new_cnt >= 16, then:
  - on the next edge, ram_wdata = acc_new[31:16] and ram_wen = 1;
  - acc shifts left by 16 and bit_cnt = new_cnt - 16.
  - At most one word is emitted per cycle, which is sufficient because the sum is at most 31.
- Latency: ram_wen is high in the cycle after the edge where the completing code is accepted. ram_wen is a registered one-cycle pulse per word.
- ram_waddr:
  - Holds the address of the current write while ram_wen is high.
  - Increments after each write and does not wrap.
  - When a write to address 2^ADDR_W-1 occurs, full is set (sticky until start/reset) and no further writes are issued.
- words_written increments on each write.
- States:
  - RUN: accepts codes. When flush is seen:
    - A code accepted in the same cycle is included in the flush.
    - Next state is FLUSH.
    - flush is ignored in states other than RUN.
  - FLUSH (1 cycle): append trailing bits (see Optional Feature). If bit_cnt > 0, emit one word zero-padded on the right. If bit_cnt == 0, no write. Then acc=0, bit_cnt=0, next state DONE.
  - DONE (1 cycle): flush_done=1, then RUN. ram_waddr continues from the same position, so the next stream appends.
- When full=1, a flush still completes its states and pulses flush_done, but performs no write. Pending bits are dropped.
- code_valid while code_ready=0: the code is not consumed; the producer holds it.

Optional Feature:
- Macro: BITSTREAM_PACKER_RBSP_TRAILING_EN.
- Defined: on entry to FLUSH, a single '1' stop bit is appended, then the word is zero-padded to the 16-bit boundary.
  - If bit_cnt was 15, the stop bit completes the word and exactly one word is written.
  - If bit_cnt was 0, word 0x8000 is written.
- Undefined: no stop bit is appended. Zero-padding only. No write if bit_cnt==0.

Test Plan:
- Reset, start, then codes (1,len1),(0b010,len3),(0xFFF,len12) on consecutive cycles -> one write: ram_wen=1 the cycle after the third accept, addr 0, data 0xAFFF, bit_cnt 0.
- Codes (0xABC,12),(0xDEF,12) then flush -> addr0=0xABCD; addr1=0xEF80 with RBSP_TRAILING_EN, 0xEF00 without; flush_done one pulse; words_written=2.
- Code (0x7FFF,15) with flush in the same cycle, TRAILING_EN -> single write 0xFFFF, no second word. Flush with bit_cnt=0 -> 0x8000 with TRAILING_EN; no write without it; flush_done in both cases.
- code_value=0xFFFF with code_len=4, then len=0 with code_valid, then code_len=20 with value 0x0000 -> upper bits masked, len0 no-op, len20 clamped to 16: writes 0xF000, then 0x0... with remaining 4 bits pending.
- ADDR_W=4: stream 17 full words -> 16 writes to addr 0..15, full=1 after the write to 15, code_ready=0, no 17th write; start clears full and addr.
- reset_n low for one cycle mid-stream with bit_cnt=9 -> all outputs return to reset values immediately (async); the next code after release is written starting at addr 0.

Source files
------------

// File: rtl/bitstream_packer_if.sv
// Handshake and RAM-write bundle for bitstream_packer: code input side,
// flush control and the word-write port towards bitstream RAM.
interface bitstream_packer_if #(
    parameter int ADDR_W = 17
);
    logic              start;
    logic              code_valid;
    logic [15:0]       code_value;
    logic [4:0]        code_len;
    logic              code_ready;
    logic              flush;
    logic              flush_done;
    logic              ram_wen;
    logic [ADDR_W-1:0] ram_waddr;
    logic [15:0]       ram_wdata;
    logic [ADDR_W:0]   words_written;
    logic              full;

    modport master (
        output start, code_valid, code_value, code_len, flush,
        input  code_ready, flush_done, ram_wen, ram_waddr, ram_wdata,
               words_written, full
    );

    modport slave (
        input  start, code_valid, code_value, code_len, flush,
        output code_ready, flush_done, ram_wen, ram_waddr, ram_wdata,
               words_written, full
    );
endinterface

// File: rtl/bitstream_packer.sv
// Packs MSB-first variable-length codes into 16-bit RAM words, with flush.
// Optional macro BITSTREAM_PACKER_RBSP_TRAILING_EN appends a '1' stop bit on flush.
module bitstream_packer #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset_n,
    bitstream_packer_if.slave bus
);
    typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    state_t            state_q, state_d;
    logic [31:0]       acc_q, acc_d;
    logic [5:0]        cnt_q, cnt_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              full_q, full_d;

    logic              ready;
    logic [4:0]        len_eff;
    logic [15:0]       masked;
    logic [5:0]        shamt;
    logic [31:0]       sum_acc;
    logic [5:0]        sum_cnt;
    logic [15:0]       flush_hi;
    logic              flush_nonempty;
    logic              emit;
    logic [15:0]       emit_word;

    function automatic logic [4:0] clamp_len(input logic [4:0] len);
        return (len > 5'd16) ? 5'd16 : len;
    endfunction

    function automatic logic [15:0] mask_code(input logic [15:0] val, input logic [4:0] len);
        return val & (16'hFFFF >> (5'd16 - len));
    endfunction

    assign ready   = (state_q == RUN) && !full_q && !bus.start;
    assign len_eff = clamp_len(bus.code_len);
    assign masked  = mask_code(bus.code_value, len_eff);
    // Left-aligned placement: code MSB lands just below the bits already held.
    assign shamt   = 6'd32 - cnt_q - {1'b0, len_eff};
    assign sum_acc = acc_q | ({16'h0000, masked} << shamt);
    assign sum_cnt = cnt_q + {1'b0, len_eff};

`ifdef BITSTREAM_PACKER_RBSP_TRAILING_EN
    assign flush_hi       = acc_q[31:16] | (16'h8000 >> cnt_q[3:0]);
    assign flush_nonempty = 1'b1;
`else
    assign flush_hi       = acc_q[31:16];
    assign flush_nonempty = (cnt_q != 6'd0);
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        wen_d     = 1'b0;
        wdata_d   = wdata_q;
        words_d   = words_q;
        full_d    = full_q;
        emit      = 1'b0;
        emit_word = 16'h0000;
        // The address advances once the previous write has been presented.
        waddr_d   = (wen_q && (waddr_q != LAST_ADDR)) ? waddr_q + ADDR_W'(1) : waddr_q;

        case (state_q)
            RUN: begin
                if (bus.code_valid && ready) begin
                    if (sum_cnt >= 6'd16) begin
                        emit      = 1'b1;
                        emit_word = sum_acc[31:16];
                        acc_d     = sum_acc << 16;
                        cnt_d     = sum_cnt - 6'd16;
                    end else begin
                        acc_d = sum_acc;
                        cnt_d = sum_cnt;
                    end
                end
                if (bus.flush) state_d = FLUSH;
            end
            FLUSH: begin
                if (flush_nonempty && !full_q) begin
                    emit      = 1'b1;
                    emit_word = flush_hi;
                end
                acc_d   = 32'h0;
                cnt_d   = 6'd0;
                state_d = DONE;
            end
            DONE:    state_d = RUN;
            default: state_d = RUN;
        endcase

        if (emit) begin
            wen_d   = 1'b1;
            wdata_d = emit_word;
            words_d = words_q + (ADDR_W+1)'(1);
            full_d  = full_q | (waddr_d == LAST_ADDR);
        end

        if (bus.start) begin
            state_d = RUN;
            acc_d   = 32'h0;
            cnt_d   = 6'd0;
            wen_d   = 1'b0;
            waddr_d = '0;
            wdata_d = 16'h0000;
            words_d = '0;
            full_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            acc_q   <= 32'h0;
            cnt_q   <= 6'd0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 16'h0000;
            words_q <= '0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            words_q <= words_d;
            full_q  <= full_d;
        end
    end

    assign bus.code_ready    = ready;
    assign bus.flush_done    = (state_q == DONE);
    assign bus.ram_wen       = wen_q;
    assign bus.ram_waddr     = waddr_q;
    assign bus.ram_wdata     = wdata_q;
    assign bus.words_written = words_q;
    assign bus.full          = full_q;
endmodule
